// File: rtl/serial_tx_param_if.sv
// Parallel-load / serial-out handshake bundle for serial_tx_param.
// The master side drives the word, controls and divider; the slave reports status and the serial bit.
interface serial_tx_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] DataIn;
  logic                  Sample;
  logic                  StartTx;
  logic [DIV_WIDTH-1:0]  ClkDiv;
  logic                  TxBusy;
  logic                  TxDone;
  logic                  DataOut;

  modport master (output DataIn, Sample, StartTx, ClkDiv, input TxBusy, TxDone, DataOut);
  modport slave  (input DataIn, Sample, StartTx, ClkDiv, output TxBusy, TxDone, DataOut);
endinterface

// File: rtl/serial_tx_param.sv
// Parameterised parallel-to-serial transmitter with programmable bit period.
// Define SERIAL_TX_PARITY_EN to append one even-parity bit after the data bits.
module serial_tx_param #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 16,
  parameter int MSB_FIRST  = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  serial_tx_param_if.slave  bus
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  dout_q, dout_d;
`ifdef SERIAL_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic                  busy, smp_ok, start_ok;
  logic [DATA_WIDTH-1:0] word, shift_nx;

  function automatic logic head(input logic [DATA_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
  endfunction

`ifdef SERIAL_TX_PARITY_EN
  assign busy = (state_q == SHIFT) || (state_q == PARITY);
`else
  assign busy = (state_q == SHIFT);
`endif
  assign smp_ok   = bus.Sample  && !busy;
  assign start_ok = bus.StartTx && !busy;
  // Same-cycle Sample bypasses the holding register so the fresh word is sent.
  assign word     = smp_ok ? bus.DataIn : hold_q;
  assign shift_nx = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    dout_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (smp_ok) hold_d = bus.DataIn;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_ok) begin
          state_d = SHIFT;
          shift_d = word;
          div_d   = bus.ClkDiv;
          cnt_d   = '0;
          bit_d   = '0;
          dout_d  = head(word);
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ^word;
`endif
        end
      end
      SHIFT: begin
        dout_d = dout_q;
        if (cnt_q == div_q) begin
          cnt_d = '0;
          if (bit_q == LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
            dout_d  = par_q;
`else
            state_d = DONE;
            dout_d  = 1'b0;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_nx;
            dout_d  = head(shift_nx);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        dout_d = dout_q;
        if (cnt_q == div_q) begin
          cnt_d   = '0;
          state_d = DONE;
          dout_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      shift_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      dout_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      dout_q  <= dout_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.TxBusy  = busy;
  assign bus.TxDone  = (state_q == DONE);
  assign bus.DataOut = dout_q;
endmodule
